id_ex_ctrl: RTL

Instruction-side counterpart of the execute-stage ALU. It decodes the 32-bit RISC-V instruction held in ID into the 3-bit ALU operation code and pipeline control bits. It also generates the immediate and detects load-use hazards. Results are registered into the ID/EX pipeline register that drives the EX stage. It sits between the IF/ID register and the ALU/forwarding logic, and supplies the `stall_o` that freezes PC and IF/ID.

---
 rtl/id_ex_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_ctrl.sv
// ID-stage decoder and ID/EX pipeline register: decodes the instruction, builds the
// immediate, detects load-use hazards and registers controls and operands for EX.
module id_ex_ctrl #(
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    input  logic        flush_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        stall_o,
    output logic        ex_valid_o,
    output logic [2:0]  ex_ALUctrl_o,
    output logic        ex_ALUSrc_o,
    output logic        ex_RegWrite_o,
    output logic        ex_MemtoReg_o,
    output logic        ex_MemRead_o,
    output logic        ex_MemWrite_o,
    output logic        ex_Branch_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [4:0]  ex_rd_o,
    output logic        ex_illegal_o
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_SRAI = 3'b110;
    localparam logic [2:0] ALU_ADDI = 3'b111;

    function automatic logic signed [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:25], inst[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_shamt(input logic [31:0] inst);
        return {27'd0, inst[24:20]};
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];

    logic               legal_p0;
    logic [2:0]         alu_p0;
    logic               alusrc_p0, regwrite_p0, memtoreg_p0, memread_p0, memwrite_p0, branch_p0;
    logic               use_rs2_p0;
    logic signed [31:0] imm_p0;

    // Stage p0: combinational decode of the instruction in ID
    always_comb begin
        legal_p0    = 1'b0;
        alu_p0      = ALU_ADD;
        alusrc_p0   = 1'b0;
        regwrite_p0 = 1'b0;
        memtoreg_p0 = 1'b0;
        memread_p0  = 1'b0;
        memwrite_p0 = 1'b0;
        branch_p0   = 1'b0;
        use_rs2_p0  = 1'b0;
        imm_p0      = '0;
        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: begin legal_p0 = 1'b1; alu_p0 = ALU_ADD; end
                    {7'b0100000, 3'b000}: begin legal_p0 = 1'b1; alu_p0 = ALU_SUB; end
                    {7'b0000000, 3'b111}: begin legal_p0 = 1'b1; alu_p0 = ALU_AND; end
                    {7'b0000000, 3'b100}: begin legal_p0 = 1'b1; alu_p0 = ALU_XOR; end
                    {7'b0000000, 3'b001}: begin legal_p0 = 1'b1; alu_p0 = ALU_SLL; end
                    {7'b0000001, 3'b000}: begin legal_p0 = 1'b1; alu_p0 = ALU_MUL; end
                    default: ;
                endcase
                regwrite_p0 = legal_p0;
                use_rs2_p0  = legal_p0;
            end
            OP_I: begin
                if (funct3 == 3'b000) begin
                    legal_p0 = 1'b1;
                    alu_p0   = ALU_ADDI;
                    imm_p0   = imm_i(inst_i);
                end else if (funct3 == 3'b101 && funct7 == 7'b0100000) begin
                    legal_p0 = 1'b1;
                    alu_p0   = ALU_SRAI;
                    imm_p0   = imm_shamt(inst_i);
                end
                regwrite_p0 = legal_p0;
                alusrc_p0   = legal_p0;
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    legal_p0    = 1'b1;
                    memread_p0  = 1'b1;
                    memtoreg_p0 = 1'b1;
                    regwrite_p0 = 1'b1;
                    alusrc_p0   = 1'b1;
                    imm_p0      = imm_i(inst_i);
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    legal_p0    = 1'b1;
                    memwrite_p0 = 1'b1;
                    alusrc_p0   = 1'b1;
                    use_rs2_p0  = 1'b1;
                    imm_p0      = imm_s(inst_i);
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    legal_p0   = 1'b1;
                    alu_p0     = ALU_SUB;
                    branch_p0  = 1'b1;
                    use_rs2_p0 = 1'b1;
                    imm_p0     = imm_b(inst_i);
                end
            end
            default: ;
        endcase
    end

    logic rd_hit_p0;
    logic hazard_p0;

    // rs1 counts as a source only for legal encodings, so junk never stalls
    assign rd_hit_p0 = (legal_p0   && (ex_rd_o == inst_i[19:15])) ||
                       (use_rs2_p0 && (ex_rd_o == inst_i[24:20]));
    assign hazard_p0 = HAZARD_EN && inst_valid_i && !flush_i &&
                       ex_valid_o && ex_MemRead_o && (ex_rd_o != 5'd0) && rd_hit_p0;
    assign stall_o   = hazard_p0;

    logic               vld_p1, illegal_p1;
    logic [2:0]         alu_p1;
    logic               alusrc_p1, regwrite_p1, memtoreg_p1, memread_p1, memwrite_p1, branch_p1;
    logic [31:0]        rs1_data_p1, rs2_data_p1;
    logic signed [31:0] imm_p1;
    logic [4:0]         rs1_p1, rs2_p1, rd_p1;

    // Stage p1: ID/EX register; bubbles and reset clear every field
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || hazard_p0 || !inst_valid_i) begin
            vld_p1      <= 1'b0;
            illegal_p1  <= 1'b0;
            alu_p1      <= '0;
            alusrc_p1   <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            branch_p1   <= 1'b0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            rd_p1       <= '0;
        end else begin
            vld_p1      <= legal_p0;
            illegal_p1  <= !legal_p0;
            alu_p1      <= alu_p0;
            alusrc_p1   <= alusrc_p0;
            regwrite_p1 <= regwrite_p0;
            memtoreg_p1 <= memtoreg_p0;
            memread_p1  <= memread_p0;
            memwrite_p1 <= memwrite_p0;
            branch_p1   <= branch_p0;
            rs1_data_p1 <= legal_p0 ? rs1_data_i : 32'd0;
            rs2_data_p1 <= legal_p0 ? rs2_data_i : 32'd0;
            imm_p1      <= imm_p0;
            rs1_p1      <= legal_p0 ? inst_i[19:15] : 5'd0;
            rs2_p1      <= legal_p0 ? inst_i[24:20] : 5'd0;
            rd_p1       <= regwrite_p0 ? inst_i[11:7] : 5'd0;
        end
    end

    assign ex_valid_o    = vld_p1;
    assign ex_illegal_o  = illegal_p1;
    assign ex_ALUctrl_o  = alu_p1;
    assign ex_ALUSrc_o   = alusrc_p1;
    assign ex_RegWrite_o = regwrite_p1;
    assign ex_MemtoReg_o = memtoreg_p1;
    assign ex_MemRead_o  = memread_p1;
    assign ex_MemWrite_o = memwrite_p1;
    assign ex_Branch_o   = branch_p1;
    assign ex_rs1_data_o = rs1_data_p1;
    assign ex_rs2_data_o = rs2_data_p1;
    assign ex_imm_o      = imm_p1;
    assign ex_rs1_o      = rs1_p1;
    assign ex_rs2_o      = rs2_p1;
    assign ex_rd_o       = rd_p1;

endmodule
